// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - sample and handshake bundle for the FFT output reorder buffer
//
// Signals (names follow the FFT-side netlist so the buffer drops in beside FFT32):
//   IN_START  - one-cycle frame strobe from the FFT; first sample follows next cycle
//   IN_R/IN_I - FFT output sample (bit-reversed order), NB bits each
//   OUT_VALID - OUT_R/OUT_I/OUT_LAST carry a valid natural-order sample
//   OUT_READY - consumer accepts the current sample
//   OUT_R/OUT_I - natural-order sample, NB bits each
//   OUT_LAST  - marks natural index N-1
//   OVERFLOW  - one-cycle pulse when an incoming frame is dropped
// Modports: master = FFT/consumer side, slave = reorder buffer.

interface fft_out_reorder_if #(
    parameter int NB = 16
);
    logic          IN_START;
    logic [NB-1:0] IN_R;
    logic [NB-1:0] IN_I;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [NB-1:0] OUT_R;
    logic [NB-1:0] OUT_I;
    logic          OUT_LAST;
    logic          OVERFLOW;

    modport master (
        output IN_START, IN_R, IN_I, OUT_READY,
        input  OUT_VALID, OUT_R, OUT_I, OUT_LAST, OVERFLOW
    );

    modport slave (
        input  IN_START, IN_R, IN_I, OUT_READY,
        output OUT_VALID, OUT_R, OUT_I, OUT_LAST, OVERFLOW
    );
endinterface

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong buffer that replays FFT32 bit-reversed output in natural order
//
// Parameters: NB (word width), N (points per frame, power of two), LOGN (log2 N).
// Ports:
//   CLK - clock, all state on posedge
//   RST - synchronous active-high reset
//   bus - fft_out_reorder_if.slave: IN_START/IN_R/IN_I in, OUT_VALID/OUT_READY
//         stream out with OUT_R/OUT_I/OUT_LAST, OVERFLOW drop pulse
// Build option: define FFTREORDER_BYPASS_EN when the upstream FFT already emits
// natural order; samples are then stored at their arrival index.

module fft_out_reorder #(
    parameter int NB   = 16,
    parameter int N    = 32,
    parameter int LOGN = 5
) (
    input  logic                CLK,
    input  logic                RST,
    fft_out_reorder_if.slave    bus
);

    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } wstate_e;

    wstate_e         state_q,    state_d;
    logic [1:0]      full_q,     full_d;
    logic            wbank_q,    wbank_d;
    logic            rbank_q,    rbank_d;
    logic [LOGN-1:0] widx_q,     widx_d;
    logic [LOGN-1:0] ridx_q,     ridx_d;
    logic            overflow_q, overflow_d;

    // Sample storage: two banks of N complex words {re, im}; not reset.
    logic [2*NB-1:0] mem_q [2][N];

    logic            mem_we;
    logic [LOGN-1:0] mem_waddr;
    logic [2*NB-1:0] rd_word;
    logic            rd_fire;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) begin
            r[b] = a[LOGN-1-b];
        end
        return r;
    endfunction

`ifdef FFTREORDER_BYPASS_EN
    assign mem_waddr = widx_q;
`else
    // Sample k of a frame belongs at natural index bitrev(k).
    assign mem_waddr = bitrev(widx_q);
`endif

    assign rd_word       = mem_q[rbank_q][ridx_q];
    assign rd_fire       = full_q[rbank_q] && bus.OUT_READY;

    assign bus.OUT_VALID = full_q[rbank_q];
    assign bus.OUT_R     = rd_word[2*NB-1:NB];
    assign bus.OUT_I     = rd_word[NB-1:0];
    assign bus.OUT_LAST  = full_q[rbank_q] && (ridx_q == LAST_IDX);
    assign bus.OVERFLOW  = overflow_q;

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        widx_d     = widx_q;
        ridx_d     = ridx_q;
        overflow_d = 1'b0;
        mem_we     = 1'b0;

        // Read side: drain the bank under rbank in natural order.
        if (rd_fire) begin
            if (ridx_q == LAST_IDX) begin
                full_d[rbank_q] = 1'b0;
                ridx_d          = '0;
                rbank_d         = ~rbank_q;
            end else begin
                ridx_d = ridx_q + 1'b1;
            end
        end

        // Write side. The drop decision looks at full_q, so a bank released by
        // the reader in this same cycle still counts as occupied.
        unique case (state_q)
            S_IDLE: begin
                if (bus.IN_START) begin
                    if (full_q[wbank_q]) begin
                        overflow_d = 1'b1;
                    end else begin
                        state_d = S_FILL;
                        widx_d  = '0;
                    end
                end
            end
            S_FILL: begin
                if (bus.IN_START) begin
                    // New frame strobe abandons the partial frame; the strobe
                    // cycle carries no sample, so nothing is written.
                    widx_d = '0;
                end else begin
                    mem_we = 1'b1;
                    if (widx_q == LAST_IDX) begin
                        // Different bank from any read-complete this cycle.
                        full_d[wbank_q] = 1'b1;
                        wbank_d         = ~wbank_q;
                        state_d         = S_IDLE;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            full_q     <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            widx_q     <= '0;
            ridx_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            widx_q     <= widx_d;
            ridx_q     <= ridx_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[wbank_q][mem_waddr] <= {bus.IN_R, bus.IN_I};
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - directed self-checking bench for fft_out_reorder

module tb_fft_out_reorder;

    localparam int NB = 16;
    localparam int N  = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fft_out_reorder_if #(.NB(NB)) bus ();

    fft_out_reorder #(.NB(NB), .N(N), .LOGN(5)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] cap_q [$];
    int          ovf_cnt = 0;

    // Capture every accepted sample as {re, im, last}; count overflow pulses.
    always @(negedge clk) begin
        if (bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1)
            cap_q.push_back({bus.OUT_R, bus.OUT_I, bus.OUT_LAST});
        if (bus.OVERFLOW === 1'b1)
            ovf_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arrival index of the sample that lands at natural index j.
    function automatic int nat_src(input int j);
`ifdef FFTREORDER_BYPASS_EN
        return j;
`else
        int r = 0;
        for (int b = 0; b < 5; b++)
            if (((j >> b) & 1) == 1) r = r + (1 << (4 - b));
        return r;
`endif
    endfunction

    function automatic logic [32:0] exp_word(input int base, input int j);
        int          s;
        logic [15:0] er;
        logic [15:0] ei;
        s  = nat_src(j);
        er = 16'(base + s);
        ei = 16'(base + s + 32);
        return {er, ei, (j == N - 1)};
    endfunction

    task automatic send_frame(input int base, input logic exp_ovf, input bit chk_rise);
        bus.IN_START = 1'b1;
        tick();
        check("ovf_pulse", 64'(bus.OVERFLOW), 64'(exp_ovf));
        bus.IN_START = 1'b0;
        for (int k = 0; k < N; k++) begin
            bus.IN_R = 16'(base + k);
            bus.IN_I = 16'(base + k + 32);
            if (chk_rise && k == N - 1) check("valid_early", 64'(bus.OUT_VALID), 64'd0);
            tick();
        end
        if (chk_rise) check("valid_rise", 64'(bus.OUT_VALID), 64'd1);
    endtask

    task automatic verify_frame(input int start, input int base, input string tag);
        for (int j = 0; j < N; j++)
            check(tag, 64'(cap_q[start + j]), 64'(exp_word(base, j)));
    endtask

    int q0;
    int o0;
    int lasts;
    int hc_idx [5] = '{0, 1, 2, 3, 31};
`ifdef FFTREORDER_BYPASS_EN
    int hc_val [5] = '{0, 1, 2, 3, 31};
`else
    int hc_val [5] = '{0, 16, 8, 24, 31};
`endif

    initial begin
        rst           = 1'b1;
        bus.IN_START  = 1'b0;
        bus.IN_R      = '0;
        bus.IN_I      = '0;
        bus.OUT_READY = 1'b0;
        repeat (3) tick();
        check("rst_valid", 64'(bus.OUT_VALID), 64'd0);
        check("rst_last",  64'(bus.OUT_LAST),  64'd0);
        check("rst_ovf",   64'(bus.OVERFLOW),  64'd0);
        rst = 1'b0;
        tick();

        // Single frame, ready held high.
        bus.OUT_READY = 1'b1;
        q0 = cap_q.size();
        send_frame(0, 1'b0, 1'b1);
        repeat (N + 2) tick();
        check("single_cnt", 64'(cap_q.size() - q0), 64'd32);
        for (int i = 0; i < 5; i++) begin
            check("single_re", 64'(cap_q[q0 + hc_idx[i]][32:17]), 64'(hc_val[i]));
            check("single_im", 64'(cap_q[q0 + hc_idx[i]][16:1]),  64'(hc_val[i] + 32));
        end
        check("single_last", 64'(cap_q[q0 + 31][0]), 64'd1);
        verify_frame(q0, 0, "single");

        // Back-to-back frames, one strobe every N+1 cycles.
        q0 = cap_q.size();
        o0 = ovf_cnt;
        for (int f = 0; f < 4; f++) send_frame(f * 64, 1'b0, 1'b0);
        repeat (N + 4) tick();
        check("b2b_cnt", 64'(cap_q.size() - q0), 64'd128);
        lasts = 0;
        for (int i = q0; i < cap_q.size(); i++) if (cap_q[i][0]) lasts++;
        check("b2b_lasts", 64'(lasts), 64'd4);
        check("b2b_ovf", 64'(ovf_cnt - o0), 64'd0);
        for (int f = 0; f < 4; f++) verify_frame(q0 + f * N, f * 64, "b2b");

        // Back-pressure: ready 1,0,1,0...; stalled outputs show the next sample.
        bus.OUT_READY = 1'b0;
        q0 = cap_q.size();
        send_frame(16'h800, 1'b0, 1'b0);
        for (int c = 0; c < 64; c++) begin
            bus.OUT_READY = (c % 2 == 0);
            if (!bus.OUT_READY && c < 63)
                check("stall_hold", 64'({bus.OUT_VALID, bus.OUT_R, bus.OUT_I, bus.OUT_LAST}),
                      64'({1'b1, exp_word(16'h800, (c + 1) / 2)}));
            tick();
        end
        bus.OUT_READY = 1'b1;
        repeat (4) tick();
        check("bp_cnt", 64'(cap_q.size() - q0), 64'd32);
        verify_frame(q0, 16'h800, "bp");

        // Overflow: two frames buffered, third dropped.
        bus.OUT_READY = 1'b0;
        q0 = cap_q.size();
        o0 = ovf_cnt;
        send_frame(16'h100, 1'b0, 1'b0);
        send_frame(16'h200, 1'b0, 1'b0);
        send_frame(16'h300, 1'b1, 1'b0);
        check("ovf_cnt", 64'(ovf_cnt - o0), 64'd1);
        check("ovf_held", 64'(cap_q.size() - q0), 64'd0);
        bus.OUT_READY = 1'b1;
        repeat (2 * N + 4) tick();
        check("ovf_out_cnt", 64'(cap_q.size() - q0), 64'd64);
        verify_frame(q0,     16'h100, "ovf_f1");
        verify_frame(q0 + N, 16'h200, "ovf_f2");

        // Restart mid-frame at sample 10.
        q0 = cap_q.size();
        o0 = ovf_cnt;
        bus.IN_START = 1'b1;
        tick();
        bus.IN_START = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.IN_R = 16'(16'h400 + k);
            bus.IN_I = 16'(16'h400 + k + 32);
            tick();
        end
        bus.IN_START = 1'b1;
        bus.IN_R     = 16'h40a;
        bus.IN_I     = 16'h42a;
        tick();
        bus.IN_START = 1'b0;
        for (int k = 0; k < N; k++) begin
            bus.IN_R = 16'(16'h500 + k);
            bus.IN_I = 16'(16'h500 + k + 32);
            tick();
        end
        repeat (N + 2) tick();
        check("rs_cnt", 64'(cap_q.size() - q0), 64'd32);
        check("rs_ovf", 64'(ovf_cnt - o0), 64'd0);
        verify_frame(q0, 16'h500, "restart");

        // Reset during drain, then a fresh frame.
        send_frame(16'h600, 1'b0, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(bus.OUT_VALID), 64'd0);
        check("mid_rst_last",  64'(bus.OUT_LAST),  64'd0);
        rst = 1'b0;
        tick();
        q0 = cap_q.size();
        send_frame(16'h700, 1'b0, 1'b1);
        repeat (N + 2) tick();
        check("post_rst_cnt", 64'(cap_q.size() - q0), 64'd32);
        verify_frame(q0, 16'h700, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
